// File: rtl/fe65p2_pkg.sv
// Shared constants and types for the FE65-P2 trigger-matched readout core.
package fe65p2_pkg;

    localparam logic [3:0] HDR_HI    = 4'hE;
    localparam logic [3:0] HDR_LO    = 4'h5;
    localparam int         TRIG_ID_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        SCAN = 2'd2,
        STOP = 2'd3
    } state_t;

endpackage

// File: rtl/fe65p2_latency_pipe.sv
// Fixed-latency delay line of per-pixel hit snapshots; the output is the
// word that entered LATENCY edges earlier.
module fe65p2_latency_pipe #(
    parameter int NPIX    = 64,
    parameter int LATENCY = 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [NPIX-1:0] i_data,
    output logic [NPIX-1:0] o_data
);

    logic [NPIX-1:0] r_stage [LATENCY];

    // Shift the snapshot words one stage per bunch crossing
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_stage[i] <= {NPIX{1'b0}};
            end
        end else begin
            r_stage[0] <= i_data;
            for (int i = 1; i < LATENCY; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_data = r_stage[LATENCY-1];

endmodule

// File: rtl/fe65p2_trig_readout.sv
// FE65-P2 trigger-matched hit readout: snapshot, latency pipe, frame FSM.
// Optional macro FE65P2_TRIG_ID_EN puts a rolling 4-bit trigger id in the header.
module fe65p2_trig_readout
    import fe65p2_pkg::*;
#(
    parameter int NPIX    = 64,
    parameter int ADDR_W  = (NPIX > 1) ? $clog2(NPIX) : 1,
    parameter int LATENCY = 16
) (
    input  logic            CLK_BX,
    input  logic            RESET_B,
    input  logic [NPIX-1:0] HIT,
    input  logic [NPIX-1:0] PIX_EN,
    input  logic            TRIGGER,
    output logic            HIT_OR,
    output logic            OUT_DATA,
    output logic            BUSY,
    output logic            TRIG_LOST
);

    localparam int CNT_W = 4;

    logic [NPIX-1:0]   w_snap_in;
    logic [NPIX-1:0]   w_pipe_out;
    logic [ADDR_W-1:0] w_prio_idx;
    logic [3:0]        w_hdr_lo;

    logic [NPIX-1:0]   r_rb;
    logic [ADDR_W-1:0] r_addr_sr;
    logic [7:0]        r_hdr_sr;
    logic [CNT_W-1:0]  r_bit_cnt;
    state_t            r_state;
    logic              r_hit_or;
    logic              r_out;
    logic              r_busy;
    logic              r_trig_lost;

    assign w_snap_in = HIT & PIX_EN;

    fe65p2_latency_pipe #(
        .NPIX    (NPIX),
        .LATENCY (LATENCY)
    ) u_pipe (
        .i_clk   (CLK_BX),
        .i_rst_n (RESET_B),
        .i_data  (w_snap_in),
        .o_data  (w_pipe_out)
    );

`ifdef FE65P2_TRIG_ID_EN
    logic [TRIG_ID_W-1:0] r_trig_id;

    // Count accepted triggers; the header carries the value before the increment
    always_ff @(posedge CLK_BX or negedge RESET_B) begin
        if (!RESET_B) begin
            r_trig_id <= {TRIG_ID_W{1'b0}};
        end else if (TRIGGER && (r_state == IDLE)) begin
            r_trig_id <= r_trig_id + TRIG_ID_W'(1);
        end else begin
            r_trig_id <= r_trig_id;
        end
    end

    assign w_hdr_lo = r_trig_id;
`else
    assign w_hdr_lo = HDR_LO;
`endif

    // Lowest set index of the readout buffer
    always_comb begin
        w_prio_idx = {ADDR_W{1'b0}};
        for (int i = NPIX - 1; i >= 0; i--) begin
            w_prio_idx = r_rb[i] ? ADDR_W'(i) : w_prio_idx;
        end
    end

    // Registered OR of the enabled hits, same edge as the snapshot
    always_ff @(posedge CLK_BX or negedge RESET_B) begin
        if (!RESET_B) begin
            r_hit_or <= 1'b0;
        end else begin
            r_hit_or <= |w_snap_in;
        end
    end

    // Frame FSM: outputs lag the state by one edge, so the first header bit follows acceptance by one cycle
    always_ff @(posedge CLK_BX or negedge RESET_B) begin
        if (!RESET_B) begin
            r_state     <= IDLE;
            r_rb        <= {NPIX{1'b0}};
            r_addr_sr   <= {ADDR_W{1'b0}};
            r_hdr_sr    <= 8'h00;
            r_bit_cnt   <= {CNT_W{1'b0}};
            r_out       <= 1'b0;
            r_busy      <= 1'b0;
            r_trig_lost <= 1'b0;
        end else begin
            r_trig_lost <= TRIGGER && (r_state != IDLE);
            case (r_state)
                IDLE: begin
                    r_out  <= 1'b0;
                    r_busy <= 1'b0;
                    if (TRIGGER) begin
                        r_rb      <= w_pipe_out;
                        r_hdr_sr  <= {HDR_HI, w_hdr_lo};
                        r_bit_cnt <= {CNT_W{1'b0}};
                        r_state   <= HDR;
                    end
                end
                HDR: begin
                    r_out    <= r_hdr_sr[7];
                    r_busy   <= 1'b1;
                    r_hdr_sr <= {r_hdr_sr[6:0], 1'b0};
                    if (r_bit_cnt == CNT_W'(7)) begin
                        r_bit_cnt <= {CNT_W{1'b0}};
                        r_state   <= SCAN;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                    end
                end
                SCAN: begin
                    r_busy <= 1'b1;
                    if (r_rb == {NPIX{1'b0}}) begin
                        r_out   <= 1'b0;
                        r_state <= STOP;
                    end else if (r_bit_cnt == {CNT_W{1'b0}}) begin
                        r_out     <= 1'b1;
                        r_addr_sr <= w_prio_idx;
                        r_bit_cnt <= CNT_W'(1);
                    end else begin
                        r_out     <= r_addr_sr[ADDR_W-1];
                        r_addr_sr <= r_addr_sr << 1'b1;
                        if (r_bit_cnt == CNT_W'(ADDR_W)) begin
                            r_rb[w_prio_idx] <= 1'b0;
                            r_bit_cnt        <= {CNT_W{1'b0}};
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        end
                    end
                end
                STOP: begin
                    r_out   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_out   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign HIT_OR    = r_hit_or;
    assign OUT_DATA  = r_out;
    assign BUSY      = r_busy;
    assign TRIG_LOST = r_trig_lost;

endmodule

// File: tb/tb_fe65p2_trig_readout.sv
// Self-checking bench for fe65p2_trig_readout: directed frames plus random traffic vs a frame-level model.
module tb_fe65p2_trig_readout;

    localparam int NPIX    = 64;
    localparam int ADDR_W  = 6;
    localparam int LATENCY = 16;
    localparam int MAXE    = 8192;

    logic            CLK_BX  = 1'b0;
    logic            RESET_B = 1'b0;
    logic [NPIX-1:0] HIT     = '0;
    logic [NPIX-1:0] PIX_EN  = '1;
    logic            TRIGGER = 1'b0;
    logic            HIT_OR;
    logic            OUT_DATA;
    logic            BUSY;
    logic            TRIG_LOST;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_n;
    int free_at;
    int busy_cnt;
    int lost_cnt;

    logic [NPIX-1:0] hist     [0:MAXE-1];
    bit              exp_out  [0:MAXE-1];
    bit              exp_busy [0:MAXE-1];
    logic [NPIX-1:0] en_all   = '1;

    fe65p2_trig_readout #(
        .NPIX    (NPIX),
        .ADDR_W  (ADDR_W),
        .LATENCY (LATENCY)
    ) dut (
        .CLK_BX    (CLK_BX),
        .RESET_B   (RESET_B),
        .HIT       (HIT),
        .PIX_EN    (PIX_EN),
        .TRIGGER   (TRIGGER),
        .HIT_OR    (HIT_OR),
        .OUT_DATA  (OUT_DATA),
        .BUSY      (BUSY),
        .TRIG_LOST (TRIG_LOST)
    );

    always #5 CLK_BX = ~CLK_BX;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s edge=%0d act=%0h exp=%0h", tag, edge_n, act, exp);
        end
    endtask

    task automatic model_reset();
        edge_n  = 0;
        free_at = 1;
        for (int i = 0; i < MAXE; i++) begin
            hist[i]     = '0;
            exp_out[i]  = 1'b0;
            exp_busy[i] = 1'b0;
        end
    endtask

    // One bunch crossing: drive inputs, advance the model, check after the edge
    task automatic step(input logic [NPIX-1:0] hit, input logic [NPIX-1:0] en, input bit trig);
        bit              q[$];
        logic [NPIX-1:0] s;
        logic [NPIX-1:0] snap;
        logic [7:0]      hdr;
        logic [5:0]      addr;
        bit              exp_lost;
        HIT     = hit;
        PIX_EN  = en;
        TRIGGER = trig;
        edge_n++;
        s = hit & en;
        hist[edge_n] = s;
        exp_lost = 1'b0;
        if (trig) begin
            if (edge_n >= free_at) begin
                snap = (edge_n > LATENCY) ? hist[edge_n - LATENCY] : '0;
                hdr  = 8'hE5;
                for (int b = 7; b >= 0; b--) q.push_back(hdr[b]);
                for (int p = 0; p < NPIX; p++) begin
                    if (snap[p]) begin
                        addr = p[5:0];
                        q.push_back(1'b1);
                        for (int b = ADDR_W - 1; b >= 0; b--) q.push_back(addr[b]);
                    end
                end
                q.push_back(1'b0);
                for (int i = 0; i < q.size(); i++) begin
                    exp_out[edge_n + 1 + i]  = q[i];
                    exp_busy[edge_n + 1 + i] = 1'b1;
                end
                free_at = edge_n + q.size() + 2;
            end else begin
                exp_lost = 1'b1;
            end
        end
        @(posedge CLK_BX);
        #1;
        check_eq("hit_or",    HIT_OR,    |s);
        check_eq("out_data",  OUT_DATA,  exp_out[edge_n]);
        check_eq("busy",      BUSY,      exp_busy[edge_n]);
        check_eq("trig_lost", TRIG_LOST, exp_lost);
        if (BUSY) busy_cnt++;
        if (TRIG_LOST) lost_cnt++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, en_all, 1'b0);
    endtask

    initial begin
        logic [NPIX-1:0] en_r;
        logic [NPIX-1:0] hit_r;
        model_reset();
        repeat (3) @(posedge CLK_BX);
        #1;
        check_eq("rst_hit_or",    HIT_OR,    1'b0);
        check_eq("rst_out_data",  OUT_DATA,  1'b0);
        check_eq("rst_busy",      BUSY,      1'b0);
        check_eq("rst_trig_lost", TRIG_LOST, 1'b0);
        @(negedge CLK_BX);
        RESET_B = 1'b1;

        // Single pixel 5 hit at edge 10, trigger at edge 26
        idle(9);
        step(64'd1 << 5, en_all, 1'b0);
        idle(15);
        busy_cnt = 0;
        step('0, en_all, 1'b1);
        idle(20);
        check_eq("busy_len_one_hit", busy_cnt, 16);

        // Pixels 60 and 3 on the same edge
        step((64'd1 << 60) | (64'd1 << 3), en_all, 1'b0);
        idle(15);
        busy_cnt = 0;
        step('0, en_all, 1'b1);
        idle(30);
        check_eq("busy_len_two_hits", busy_cnt, 23);

        // Empty frame, then retrigger on the stop-bit cycle (lost) and the next one (accepted)
        busy_cnt = 0;
        lost_cnt = 0;
        step('0, en_all, 1'b1);
        idle(9);
        check_eq("busy_len_empty", busy_cnt, 9);
        step('0, en_all, 1'b1);
        step('0, en_all, 1'b1);
        idle(15);
        check_eq("busy_len_back2back", busy_cnt, 18);
        check_eq("lost_on_stop_bit", lost_cnt, 1);

        // Second trigger 4 cycles after an accepted one
        lost_cnt = 0;
        step('0, en_all, 1'b1);
        idle(3);
        step('0, en_all, 1'b1);
        idle(20);
        check_eq("lost_pulse_count", lost_cnt, 1);

        // Disabled pixel 7 never shows up
        en_r = ~(64'd1 << 7);
        step(64'd1 << 7, en_r, 1'b0);
        for (int i = 0; i < 15; i++) step('0, en_r, 1'b0);
        busy_cnt = 0;
        step('0, en_r, 1'b1);
        for (int i = 0; i < 12; i++) step('0, en_r, 1'b0);
        check_eq("busy_len_masked", busy_cnt, 9);

        // Randomized traffic with sparse hits and occasional masked pixels
        en_r = en_all;
        for (int c = 0; c < 1500; c++) begin
            if ((c % 200) == 0) begin
                en_r = ($urandom_range(1, 0) == 0) ? en_all : ~(64'd1 << $urandom_range(63, 0));
            end
            hit_r = '0;
            if ($urandom_range(3, 0) == 0) begin
                hit_r = 64'd1 << $urandom_range(63, 0);
                if ($urandom_range(1, 0) == 0) hit_r = hit_r | (64'd1 << $urandom_range(63, 0));
            end
            step(hit_r, en_r, $urandom_range(9, 0) == 0);
        end
        idle(500);

        // Reset in the middle of SCAN
        step(64'd1 << 20, en_all, 1'b0);
        idle(15);
        step('0, en_all, 1'b1);
        idle(11);
        step(64'd1 << 9, en_all, 1'b0);
        check_eq("busy_before_reset", BUSY, 1'b1);
        #3;
        RESET_B = 1'b0;
        HIT     = '0;
        #1;
        check_eq("async_rst_out_data", OUT_DATA, 1'b0);
        check_eq("async_rst_busy",     BUSY,     1'b0);
        check_eq("async_rst_hit_or",   HIT_OR,   1'b0);
        @(negedge CLK_BX);
        @(negedge CLK_BX);
        model_reset();
        RESET_B = 1'b1;
        idle(4);
        busy_cnt = 0;
        step('0, en_all, 1'b1);
        idle(12);
        check_eq("busy_len_after_reset", busy_cnt, 9);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
